regfile: RTL

//   Architectural register file with ROB-tag renaming. Sits between decoder/issue and the ROB.

---
 rtl/regfile_if.sv | 57 +++++
 rtl/regfile.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_if.sv
// regfile_if: groups the decoder/issue, operand lookup, ROB search and ROB
// commit signals of the rename register file.
//   master : environment side (decoder, issue, ROB) -- drives requests
//   slave  : register file side -- answers lookups and drives search tags
// Handshake semantics: every *_ready input here is a single-cycle qualifier
// (valid-style). The register file never back-pressures, so when a
// qualifier is high the accompanying payload is consumed at the next
// rising clock edge, provided rdy_in is high. Lookups are purely
// combinational and carry no handshake.
interface regfile_if #(
  parameter int ROB_WIDTH = 3,
  parameter int XLEN      = 32
) ();
  // issue / rename
  logic                 dec_ready;
  logic [4:0]           dec_rd;
  logic [ROB_WIDTH-1:0] dec_rob_id;
  // operand lookup
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  logic                 rs1_has_dep;
  logic                 rs2_has_dep;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;
  // ROB search ports
  logic [ROB_WIDTH-1:0] search_rob_id_1;
  logic [ROB_WIDTH-1:0] search_rob_id_2;
  logic                 search_ready_1;
  logic                 search_ready_2;
  logic [XLEN-1:0]      search_val_1;
  logic [XLEN-1:0]      search_val_2;
  // ROB commit
  logic                 commit_ready;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic [4:0]           commit_reg_id;
  logic [XLEN-1:0]      commit_val;

  modport master (
    output dec_ready, dec_rd, dec_rob_id,
    output rs1_id, rs2_id,
    input  rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_tag, rs2_tag,
    input  search_rob_id_1, search_rob_id_2,
    output search_ready_1, search_ready_2, search_val_1, search_val_2,
    output commit_ready, commit_rob_id, commit_reg_id, commit_val
  );

  modport slave (
    input  dec_ready, dec_rd, dec_rob_id,
    input  rs1_id, rs2_id,
    output rs1_val, rs2_val, rs1_has_dep, rs2_has_dep, rs1_tag, rs2_tag,
    output search_rob_id_1, search_rob_id_2,
    input  search_ready_1, search_ready_2, search_val_1, search_val_2,
    input  commit_ready, commit_rob_id, commit_reg_id, commit_val
  );
endinterface

// File: rtl/regfile.sv
// regfile: architectural register file with ROB-tag renaming.
// Records which ROB entry will produce each register, answers two operand
// lookups per cycle (ready value or pending tag, with forwarding from the
// commit port and the ROB search ports), retires values on commit and drops
// all rename state on a flush.
// Ports:
//   clk_in    - system clock
//   rst_n_in  - asynchronous active-low reset
//   rdy_in    - global stall; state holds while low
//   clear     - ROB flush, acted on only when rdy_in=1
//   bus       - regfile_if.slave: issue, lookup, ROB search, ROB commit
module regfile #(
  parameter int ROB_WIDTH = 3,
  parameter int XLEN      = 32
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      rdy_in,
  input  logic      clear,
  regfile_if.slave  bus
);

  typedef struct packed {
    logic                 has_dep;
    logic [ROB_WIDTH-1:0] tag;
    logic [XLEN-1:0]      val;
  } lookup_t;

  logic [XLEN-1:0]      regs_q      [32];
  logic [XLEN-1:0]      regs_d      [32];
  logic [31:0]          dep_valid_q;
  logic [31:0]          dep_valid_d;
  logic [ROB_WIDTH-1:0] dep_tag_q   [32];
  logic [ROB_WIDTH-1:0] dep_tag_d   [32];

  // ---------------- next-state ----------------
  always_comb begin
    regs_d      = regs_q;
    dep_valid_d = dep_valid_q;
    dep_tag_d   = dep_tag_q;
    if (rdy_in) begin
      if (bus.commit_ready && bus.commit_reg_id != 5'd0) begin
        regs_d[bus.commit_reg_id] = bus.commit_val;
        // Only the rename that produced this value is released; a younger
        // rename of the same register keeps it pending.
        if (dep_tag_q[bus.commit_reg_id] == bus.commit_rob_id)
          dep_valid_d[bus.commit_reg_id] = 1'b0;
      end
      // Flush beats a same-cycle issue; issue beats a same-cycle commit
      // release because it is applied after it.
      if (clear) begin
        dep_valid_d = '0;
      end else if (bus.dec_ready && bus.dec_rd != 5'd0) begin
        dep_valid_d[bus.dec_rd] = 1'b1;
        dep_tag_d[bus.dec_rd]   = bus.dec_rob_id;
      end
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i]    <= '0;
        dep_tag_q[i] <= '0;
      end
      dep_valid_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i]    <= regs_d[i];
        dep_tag_q[i] <= dep_tag_d[i];
      end
      dep_valid_q <= dep_valid_d;
    end
  end

  // ---------------- operand lookup ----------------
  logic [4:0]      rs_id    [2];
  logic            s_ready  [2];
  logic [XLEN-1:0] s_val    [2];
  lookup_t         res      [2];

  assign rs_id[0]   = bus.rs1_id;
  assign rs_id[1]   = bus.rs2_id;
  assign s_ready[0] = bus.search_ready_1;
  assign s_ready[1] = bus.search_ready_2;
  assign s_val[0]   = bus.search_val_1;
  assign s_val[1]   = bus.search_val_2;

  // x0 needs no special case: it is never written nor renamed, so it
  // always reads regs_q[0] = 0 with no dependency.
  always_comb begin
    res[0] = '0;
    res[1] = '0;
    for (int p = 0; p < 2; p++) begin
      if (dep_valid_q[rs_id[p]]) begin
        if (bus.commit_ready && bus.commit_rob_id == dep_tag_q[rs_id[p]]) begin
          res[p].val = bus.commit_val;
        end else if (s_ready[p]) begin
          res[p].val = s_val[p];
        end else begin
          res[p].has_dep = 1'b1;
          res[p].tag     = dep_tag_q[rs_id[p]];
        end
      end else begin
        res[p].val = regs_q[rs_id[p]];
      end
    end
  end

  assign bus.rs1_val         = res[0].val;
  assign bus.rs1_has_dep     = res[0].has_dep;
  assign bus.rs1_tag         = res[0].tag;
  assign bus.rs2_val         = res[1].val;
  assign bus.rs2_has_dep     = res[1].has_dep;
  assign bus.rs2_tag         = res[1].tag;
  assign bus.search_rob_id_1 = dep_tag_q[bus.rs1_id];
  assign bus.search_rob_id_2 = dep_tag_q[bus.rs2_id];

endmodule
